// File: rtl/chan_ctlr_mc.sv
// Inter-CPU channel controller: SEND / RECV / QUERY / CONV ops over the shared message bus.
// Define CHAN_CTLR_TIMEOUT_EN to compile in the WAIT_RX receive timeout (err on expiry).
module chan_ctlr_mc #(
  parameter int unsigned      DATA_W          = 32,
  parameter int unsigned      ADDR_W          = 32,
  parameter int unsigned      MSG_W           = 8,
  parameter int unsigned      HDR_SPACE       = 16,
  parameter logic [MSG_W-1:0] MSG_CHAN_SET    = MSG_W'(8'h10),
  parameter logic [MSG_W-1:0] MSG_THREAD_ADDR = MSG_W'(8'h11),
  parameter int unsigned      TIMEOUT         = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_oe,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_mode,
  input  logic [DATA_W-1:0] op_src1,
  input  logic [ADDR_W-1:0] op_src0,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DATA_W-1:0] base_addr_data,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] dst,
  input  logic              bus_busy,
  output logic [MSG_W-1:0]  msg_out,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              msg_pulse,
  output logic              strb_o,
  input  logic [MSG_W-1:0]  msg_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] addr_in
);

  typedef enum logic [2:0] {S_IDLE, S_SEND_SET, S_SEND_TA, S_WAIT_RX, S_DONE} state_t;
  typedef enum logic [1:0] {MODE_SEND = 2'b00, MODE_RECV = 2'b01, MODE_QUERY = 2'b10,
                            MODE_CONV = 2'b11} mode_t;

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d;
  logic [DATA_W-1:0] src1_q, src1_d, based_q, based_d, dst_q, dst_d, data_q, data_d;
  logic [ADDR_W-1:0] src0_q, src0_d, base_q, base_d, addr_q, addr_d;
  logic [MSG_W-1:0]  msg_q, msg_d;
  logic              op_ready_q, done_q, done_d, pulse_q, pulse_d, strb_q, strb_d;
  logic              rx_match;

`ifdef CHAN_CTLR_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 32'd0);
  assign err = 1'b0;
`endif

  // Our own CHAN_SET is still on the bus the cycle after it goes out; never match it.
  assign rx_match = (msg_in == MSG_CHAN_SET) && (addr_in == src0_q) && !pulse_q;

  // Strobes and bus drive only appear in enabled cycles; registers hold while clk_oe=0.
  assign op_ready  = op_ready_q;
  assign dst       = dst_q;
  assign done      = done_q & clk_oe;
  assign msg_pulse = pulse_q & clk_oe;
  assign strb_o    = strb_q & clk_oe;
  assign msg_out   = clk_oe ? msg_q : '0;
  assign data_out  = clk_oe ? data_q : '0;
  assign addr_out  = clk_oe ? addr_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= MODE_SEND;
      src1_q     <= '0;
      src0_q     <= '0;
      base_q     <= '0;
      based_q    <= '0;
      dst_q      <= '0;
      op_ready_q <= 1'b1;
      done_q     <= 1'b0;
      pulse_q    <= 1'b0;
      strb_q     <= 1'b0;
      msg_q      <= '0;
      data_q     <= '0;
      addr_q     <= '0;
`ifdef CHAN_CTLR_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else if (clk_oe) begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      src1_q     <= src1_d;
      src0_q     <= src0_d;
      base_q     <= base_d;
      based_q    <= based_d;
      dst_q      <= dst_d;
      op_ready_q <= (state_d == S_IDLE);
      done_q     <= done_d;
      pulse_q    <= pulse_d;
      strb_q     <= strb_d;
      msg_q      <= msg_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
`ifdef CHAN_CTLR_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    src1_d  = src1_q;
    src0_d  = src0_q;
    base_d  = base_q;
    based_d = based_q;
    dst_d   = dst_q;
    done_d  = 1'b0;
    pulse_d = 1'b0;
    strb_d  = 1'b0;
    msg_d   = '0;
    data_d  = '0;
    addr_d  = '0;
`ifdef CHAN_CTLR_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          mode_d  = mode_t'(op_mode);
          src1_d  = op_src1;
          src0_d  = op_src0;
          base_d  = base_addr;
          based_d = base_addr_data;
          dst_d   = '0;
`ifdef CHAN_CTLR_TIMEOUT_EN
          cnt_d   = '0;
          err_d   = 1'b0;
`endif
          case (mode_t'(op_mode))
            MODE_RECV: state_d = S_WAIT_RX;
            MODE_CONV: begin
              dst_d   = op_src1 + base_addr_data;
              state_d = S_DONE;
            end
            default:   state_d = S_SEND_SET;
          endcase
        end
      end
      S_SEND_SET: begin
        if (!bus_busy) begin
          pulse_d = 1'b1;
          msg_d   = MSG_CHAN_SET;
          data_d  = src1_q;
          addr_d  = src0_q;
          strb_d  = (mode_q == MODE_SEND);
          state_d = (mode_q == MODE_SEND) ? S_SEND_TA : S_WAIT_RX;
        end
      end
      S_SEND_TA: begin
        strb_d = 1'b1;
        if (!bus_busy) begin
          pulse_d = 1'b1;
          msg_d   = MSG_THREAD_ADDR;
          data_d  = based_q - DATA_W'(HDR_SPACE);
          addr_d  = base_q - ADDR_W'(HDR_SPACE);
          state_d = S_DONE;
        end
      end
      S_WAIT_RX: begin
        if (rx_match) begin
          dst_d   = data_in;
          state_d = S_DONE;
        end
`ifdef CHAN_CTLR_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          dst_d   = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_chan_ctlr_mc.sv
// Self-checking bench for chan_ctlr_mc: randomized ops against a lock-step message-schedule model.
module tb_chan_ctlr_mc;
  localparam int unsigned TO = 4;
`ifdef CHAN_CTLR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [7:0] M_SET = 8'h10;
  localparam logic [7:0] M_TA  = 8'h11;
  localparam logic [1:0] OP_SEND = 2'b00, OP_RECV = 2'b01, OP_QUERY = 2'b10, OP_CONV = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1, clk_oe = 1'b1, op_valid = 1'b0, bus_busy = 1'b0;
  logic        op_ready, done, err, msg_pulse, strb_o;
  logic [1:0]  op_mode = 2'b00;
  logic [31:0] op_src1 = '0, op_src0 = '0, base_addr = '0, base_addr_data = '0;
  logic [31:0] dst, data_out, addr_out, data_in = '0, addr_in = '0;
  logic [7:0]  msg_out, msg_in = '0;

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int gate_viol = 0;
  int zero_viol = 0;

  typedef struct { logic [7:0] m; logic [31:0] d; logic [31:0] a; int c; } msg_ev_t;
  typedef struct { int c; logic [31:0] dst; logic err; } done_ev_t;
  msg_ev_t  msg_log[$];
  done_ev_t done_log[$];
  int       strb_log[$];

  chan_ctlr_mc #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .clk_oe(clk_oe), .op_valid(op_valid), .op_ready(op_ready),
    .op_mode(op_mode), .op_src1(op_src1), .op_src0(op_src0), .base_addr(base_addr),
    .base_addr_data(base_addr_data), .done(done), .err(err), .dst(dst), .bus_busy(bus_busy),
    .msg_out(msg_out), .data_out(data_out), .addr_out(addr_out), .msg_pulse(msg_pulse),
    .strb_o(strb_o), .msg_in(msg_in), .data_in(data_in), .addr_in(addr_in));

  always #5 clk = ~clk;

  // Bus/strobe recorder, sampled mid-cycle after inputs have settled.
  always @(negedge clk) begin
    cyc_n = cyc_n + 1;
    if (msg_pulse) msg_log.push_back('{msg_out, data_out, addr_out, cyc_n});
    if (done) done_log.push_back('{cyc_n, dst, err});
    if (strb_o) strb_log.push_back(cyc_n);
    if (!clk_oe && (msg_pulse || done || strb_o)) gate_viol = gate_viol + 1;
    if (!msg_pulse && (msg_out != 0 || data_out != 0 || addr_out != 0)) zero_viol = zero_viol + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Runs one op; oe/busy/reply modes: 0 quiet, 1 directed pattern, 2 random.
  task automatic run_op(input logic [1:0] mode, input logic [31:0] s1, input logic [31:0] s0,
                        input logic [31:0] ba, input logic [31:0] bad, input int oe_mode,
                        input int busy_mode, input int rep_mode, input int max_c, input string tag,
                        output int done_rel, output int first_rel, output logic [31:0] dst_o,
                        output logic err_o);
    msg_ev_t pend[$], exp_m[$];
    int exp_s[$];
    msg_ev_t ev;
    int m0, d0, st0, g0, z0, base, phase, wait_e, exp_done, fin, rep_stage, n;
    logic [31:0] exp_dst;
    logic exp_err, dst_chk, oe, busy, match;
    m0 = msg_log.size(); d0 = done_log.size(); st0 = strb_log.size();
    g0 = gate_viol; z0 = zero_viol;
    clk_oe = 1'b1; bus_busy = 1'b0; msg_in = '0; addr_in = '0; data_in = '0;
    for (int k = 0; k < 20 && op_ready !== 1'b1; k++) tick();
    checks++;
    if (op_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_before: got %b expected 1", tag, op_ready);
    end
    op_valid = 1'b1; op_mode = mode; op_src1 = s1; op_src0 = s0;
    base_addr = ba; base_addr_data = bad;
    base = cyc_n + 1;
    tick();
    op_valid = 1'b0; op_mode = 2'($urandom); op_src1 = $urandom; op_src0 = $urandom;
    base_addr = $urandom; base_addr_data = $urandom;
    exp_dst = '0; exp_err = 1'b0; dst_chk = 1'b1; phase = 1;
    case (mode)
      OP_SEND: begin
        pend.push_back('{M_SET, s1, s0, 0});
        pend.push_back('{M_TA, bad - 32'd16, ba - 32'd16, 0});
        dst_chk = 1'b0;
      end
      OP_QUERY: pend.push_back('{M_SET, s1, s0, 0});
      OP_RECV:  phase = 2;
      default: begin phase = 3; exp_dst = s1 + bad; end
    endcase
    wait_e = 0; exp_done = -1; fin = 0; rep_stage = 0;
    for (int r = 1; r <= max_c; r++) begin
      oe   = (oe_mode == 0) ? 1'b1 : (oe_mode == 1) ? r[0] : ($urandom % 10 < 7);
      busy = (busy_mode == 0) ? 1'b0 : (busy_mode == 1) ? (r <= 3) : ($urandom % 10 < 3);
      msg_in = '0; addr_in = $urandom; data_in = $urandom;
      if (phase == 2 && wait_e >= 1) begin
        if (rep_mode == 1) begin
          msg_in = M_SET;
          if (rep_stage == 0) begin addr_in = 32'd6; data_in = 32'h99; rep_stage = 1; end
          else begin addr_in = 32'd7; data_in = 32'h55; end
        end else if (rep_mode == 2) begin
          n = (wait_e >= 8) ? 3 : int'($urandom % 4);
          case (n)
            1: begin msg_in = M_SET; addr_in = s0 + 32'd1; end
            2: begin msg_in = M_TA;  addr_in = s0; end
            3: begin msg_in = M_SET; addr_in = s0; end
            default: msg_in = '0;
          endcase
        end
      end
      clk_oe = oe; bus_busy = busy;
      tick();
      if (oe) begin
        case (phase)
          1: begin
            if (!busy) begin
              ev = pend.pop_front(); ev.c = r; exp_m.push_back(ev);
              if (mode == OP_SEND) exp_s.push_back(r);
              if (pend.size() == 0) phase = (mode == OP_SEND) ? 3 : 2;
            end else if (mode == OP_SEND && exp_m.size() > 0) exp_s.push_back(r);
          end
          2: begin
            wait_e++;
            match = (msg_in == M_SET) && (addr_in == s0);
            if (match) begin exp_dst = data_in; phase = 3; end
            else if (TO_EN && wait_e == TO) begin exp_err = 1'b1; exp_dst = '0; phase = 3; end
          end
          3: begin exp_done = r; phase = 4; end
          default: ;
        endcase
      end
      if (phase == 4) begin
        fin++;
        if (fin > 3) break;
      end
    end
    clk_oe = 1'b1; bus_busy = 1'b0; msg_in = '0;
    if (phase == 4) begin
      checks++;
      if (op_ready !== 1'b1) begin
        errors++; $display("FAIL %s ready_after: got %b expected 1", tag, op_ready);
      end
    end
    if (phase != 4 || op_ready !== 1'b1) begin
      rst = 1'b1; tick(); rst = 1'b0;
    end
    n = msg_log.size() - m0;
    checks++;
    if (n !== exp_m.size()) begin
      errors++; $display("FAIL %s msg_count: got %0d expected %0d", tag, n, exp_m.size());
    end
    for (int i = 0; i < n && i < exp_m.size(); i++) begin
      ev = msg_log[m0 + i];
      checks++;
      if (ev.m !== exp_m[i].m || ev.d !== exp_m[i].d || ev.a !== exp_m[i].a ||
          (ev.c - base) !== exp_m[i].c) begin
        errors++;
        $display("FAIL %s msg[%0d]: got m=%h d=%h a=%h cyc=%0d expected m=%h d=%h a=%h cyc=%0d",
                 tag, i, ev.m, ev.d, ev.a, ev.c - base, exp_m[i].m, exp_m[i].d, exp_m[i].a,
                 exp_m[i].c);
      end
    end
    n = done_log.size() - d0;
    checks++;
    if (n !== ((exp_done >= 0) ? 1 : 0)) begin
      errors++; $display("FAIL %s done_count: got %0d expected %0d", tag, n, (exp_done >= 0) ? 1 : 0);
    end
    done_rel = (n >= 1) ? done_log[d0].c - base : -1;
    dst_o    = (n >= 1) ? done_log[d0].dst : '0;
    err_o    = (n >= 1) ? done_log[d0].err : 1'b0;
    first_rel = (msg_log.size() > m0) ? msg_log[m0].c - base : -1;
    if (n >= 1 && exp_done >= 0) begin
      checks++;
      if (done_rel !== exp_done || err_o !== exp_err || (dst_chk && dst_o !== exp_dst)) begin
        errors++;
        $display("FAIL %s done: got cyc=%0d err=%b dst=%h expected cyc=%0d err=%b dst=%h",
                 tag, done_rel, err_o, dst_o, exp_done, exp_err, exp_dst);
      end
    end
    n = strb_log.size() - st0;
    checks++;
    if (n !== exp_s.size()) begin
      errors++; $display("FAIL %s strb_count: got %0d expected %0d", tag, n, exp_s.size());
    end
    for (int i = 0; i < n && i < exp_s.size(); i++) begin
      checks++;
      if ((strb_log[st0 + i] - base) !== exp_s[i]) begin
        errors++; $display("FAIL %s strb[%0d]: got cyc=%0d expected cyc=%0d", tag, i,
                           strb_log[st0 + i] - base, exp_s[i]);
      end
    end
    checks++;
    if ((gate_viol - g0) !== 0 || (zero_viol - z0) !== 0) begin
      errors++; $display("FAIL %s gating: got gate=%0d zero=%0d expected 0 0", tag,
                         gate_viol - g0, zero_viol - z0);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({done, err, dst, msg_pulse, msg_out, data_out, addr_out, strb_o} !== '0) begin
      errors++; $display("FAIL %s outputs: got done=%b err=%b dst=%h pulse=%b msg=%h strb=%b expected 0",
                         tag, done, err, dst, msg_pulse, msg_out, strb_o);
    end
    checks++;
    if (op_ready !== 1'b1) begin
      errors++; $display("FAIL %s op_ready: got %b expected 1", tag, op_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    check_idle_outputs("reset");
  endtask

  task automatic test_conv();
    int dr, fm; logic [31:0] d; logic e;
    run_op(OP_CONV, 32'h20, 32'h3, 32'h0, 32'h1000, 0, 0, 0, 20, "conv", dr, fm, d, e);
    checks++;
    if (dr !== 1 || d !== 32'h1020 || fm !== -1) begin
      errors++; $display("FAIL conv_direct: got done=%0d dst=%h msg=%0d expected 1 00001020 -1", dr, d, fm);
    end
  endtask

  task automatic test_send();
    int dr, fm; logic [31:0] d; logic e;
    run_op(OP_SEND, 32'hAB, 32'd5, 32'h8, 32'h40, 0, 0, 0, 20, "send", dr, fm, d, e);
    checks++;
    if (dr !== 3 || fm !== 1) begin
      errors++; $display("FAIL send_direct: got done=%0d first=%0d expected 3 1", dr, fm);
    end
  endtask

  task automatic test_query_busy();
    int dr, fm; logic [31:0] d; logic e;
    run_op(OP_QUERY, 32'h1234, 32'd7, 32'h100, 32'h200, 0, 1, 1, 40, "query", dr, fm, d, e);
    checks++;
    if (fm !== 4 || d !== 32'h55 || e !== 1'b0) begin
      errors++; $display("FAIL query_direct: got first=%0d dst=%h err=%b expected 4 00000055 0", fm, d, e);
    end
  endtask

  task automatic test_timeout();
    int dr, fm; logic [31:0] d; logic e;
    run_op(OP_RECV, 32'h0, 32'd9, 32'h0, 32'h0, 0, 0, 0, 100, "timeout", dr, fm, d, e);
    checks++;
`ifdef CHAN_CTLR_TIMEOUT_EN
    if (dr !== 5 || e !== 1'b1 || d !== 32'h0) begin
      errors++; $display("FAIL timeout_direct: got done=%0d err=%b dst=%h expected 5 1 0", dr, e, d);
    end
`else
    if (dr !== -1) begin
      errors++; $display("FAIL timeout_direct: got done=%0d expected none", dr);
    end
`endif
  endtask

  task automatic test_clk_oe();
    int dr, fm; logic [31:0] d; logic e;
    run_op(OP_SEND, 32'hC0DE, 32'd3, 32'h4, 32'h8, 1, 0, 0, 30, "clk_oe", dr, fm, d, e);
    checks++;
    if (dr !== 5 || fm !== 1) begin
      errors++; $display("FAIL clk_oe_direct: got done=%0d first=%0d expected 5 1", dr, fm);
    end
  endtask

  task automatic test_reset_midop();
    int dr, fm; logic [31:0] d; logic e;
    run_op(OP_RECV, 32'h0, 32'd11, 32'h0, 32'h0, 0, 0, 0, 2, "rst_wait", dr, fm, d, e);
    check_idle_outputs("rst_wait");
    run_op(OP_SEND, 32'h77, 32'd12, 32'h50, 32'h60, 0, 0, 0, 1, "rst_send", dr, fm, d, e);
    check_idle_outputs("rst_send");
    run_op(OP_CONV, 32'h1, 32'h0, 32'h0, 32'h2, 0, 0, 0, 20, "post_rst", dr, fm, d, e);
  endtask

  task automatic test_random();
    int dr, fm; logic [31:0] d; logic e;
    for (int i = 0; i < 25; i++) begin
      run_op(2'($urandom), $urandom, 32'($urandom % 16), $urandom, $urandom, 2, 2, 2, 150,
             "random", dr, fm, d, e);
    end
  endtask

  initial begin
    test_reset();
    test_conv();
    test_send();
    test_query_busy();
    test_timeout();
    test_clk_oe();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
